// File: rtl/adc_sched_pkg.sv
// ---------------------------------------------------------------------------
// adc_sched_pkg
// Shared types and helpers for the ADC channel scheduler:
//   - sched_state_e : scheduler FSM states
//   - ADC_CODE_W    : width of the averaged ADC code
//   - ch_width()    : channel-select width for a given channel count
//   - rr_next()     : round-robin search for the next participating channel
// ---------------------------------------------------------------------------
package adc_sched_pkg;

    localparam int ADC_CODE_W = 12;
    localparam int MAX_CH     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SETTLE,
        ST_ACCUM,
        ST_WAIT,
        ST_CAPTURE
    } sched_state_e;

    // A single channel still needs a 1-bit select so the port exists.
    function automatic int ch_width(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

    // First set mask bit at or after ptr, wrapping at num_ch.
    // Caller guarantees mask != 0 and ptr < num_ch; returns 0 otherwise.
    function automatic logic [2:0] rr_next(input logic [MAX_CH-1:0] mask,
                                           input logic [2:0]        ptr,
                                           input int                num_ch);
        logic [2:0] sel;
        logic       found;
        int         idx;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (i < num_ch) begin
                idx = int'(ptr) + i;
                if (idx >= num_ch) begin
                    idx = idx - num_ch;
                end
                if (!found && mask[idx]) begin
                    found = 1'b1;
                    sel   = 3'(idx);
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/adc_channel_scheduler_sample_tick_gen.sv
// ---------------------------------------------------------------------------
// sample_tick_gen
// Free-running sample-rate divider. While run is high the counter cycles
// 0..SAMPLE_DIV-1 and tick is asserted on the SAMPLE_DIV-1 cycle. While run
// is low the counter is held at zero, so the first tick after run rises
// lands SAMPLE_DIV cycles after the last run-low cycle.
// Ports:
//   clk   in  system clock
//   reset in  synchronous active-high reset
//   run   in  counter enable
//   tick  out one-cycle sample tick (combinational from the counter)
// ---------------------------------------------------------------------------
module sample_tick_gen
    import adc_sched_pkg::*;
#(
    parameter int SAMPLE_DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = $clog2(SAMPLE_DIV);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_end;

    always_comb begin
        at_end = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
        cnt_d  = cnt_q;
        if (!run || at_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign tick = run && at_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_channel_scheduler.sv
// ---------------------------------------------------------------------------
// adc_channel_scheduler
// Round-robin time-multiplexer for one PWM-ADC averager. Per channel:
// select -> flush averager (CLEAR) -> discard SETTLE_SAMPLES ticks ->
// strobe 2^POWER samples -> one latency cycle (WAIT) -> capture (CAPTURE).
// Optional build macro ADC_SCHED_HOLD_EN adds a per-channel result bank
// with ports rd_ch / rd_data (combinational read, out-of-range reads 0).
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   enable            run scheduler; low aborts the current window
//   ch_mask           channel participation mask, sampled at selection
//   avg_Q             averaged code from the averager
//   ch_sel            front-end mux select
//   avg_EN, avg_clr   one-cycle sample strobe / flush to the averager
//   result_valid      one-cycle pulse, result_data/result_ch updated
//   result_data/_ch   captured code and its channel
//   ready             high while idle
// All outputs are registered.
// ---------------------------------------------------------------------------
module adc_channel_scheduler
    import adc_sched_pkg::*;
#(
    parameter  int NUM_CH         = 3,
    parameter  int POWER          = 8,
    parameter  int SAMPLE_DIV     = 1000,
    parameter  int SETTLE_SAMPLES = 4,
    localparam int CH_W           = ch_width(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_CH-1:0]     ch_mask,
    input  logic [ADC_CODE_W-1:0] avg_Q,
`ifdef ADC_SCHED_HOLD_EN
    input  logic [CH_W-1:0]       rd_ch,
    output logic [ADC_CODE_W-1:0] rd_data,
`endif
    output logic [CH_W-1:0]       ch_sel,
    output logic                  avg_EN,
    output logic                  avg_clr,
    output logic                  result_valid,
    output logic [ADC_CODE_W-1:0] result_data,
    output logic [CH_W-1:0]       result_ch,
    output logic                  ready
);

    localparam int SAMPLE_W = POWER + 1;
    localparam int SETTLE_W = 4;

    sched_state_e          state_q, state_d;
    logic [CH_W-1:0]       ch_sel_q, ch_sel_d;
    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [SAMPLE_W-1:0]   sample_cnt_q, sample_cnt_d;
    logic                  avg_en_q, avg_en_d;
    logic                  avg_clr_q, avg_clr_d;
    logic                  result_valid_q, result_valid_d;
    logic [ADC_CODE_W-1:0] result_data_q, result_data_d;
    logic [CH_W-1:0]       result_ch_q, result_ch_d;
    logic                  ready_q, ready_d;

    logic                  tick;
    logic                  run;
    logic                  have_ch;
    logic [CH_W-1:0]       ptr_after_cap;

    // Counter is held at zero in IDLE and CLEAR, which both zeroes it at
    // the flush and keeps it stopped while idle.
    assign run     = (state_q != ST_IDLE) && (state_q != ST_CLEAR);
    assign have_ch = enable && (|ch_mask);
    assign ptr_after_cap = (ch_sel_q == CH_W'(NUM_CH - 1)) ? '0 : ch_sel_q + CH_W'(1);

    sample_tick_gen #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .tick  (tick)
    );

    always_comb begin
        state_d        = state_q;
        ch_sel_d       = ch_sel_q;
        rr_ptr_d       = rr_ptr_q;
        settle_cnt_d   = settle_cnt_q;
        sample_cnt_d   = sample_cnt_q;
        avg_en_d       = 1'b0;
        result_valid_d = 1'b0;
        result_data_d  = result_data_q;
        result_ch_d    = result_ch_q;

        case (state_q)
            ST_IDLE: begin
                if (have_ch) begin
                    ch_sel_d = CH_W'(rr_next(MAX_CH'(ch_mask), 3'(rr_ptr_q), NUM_CH));
                    state_d  = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                settle_cnt_d = '0;
                sample_cnt_d = '0;
                state_d      = (SETTLE_SAMPLES == 0) ? ST_ACCUM : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (tick) begin
                    if (settle_cnt_q == SETTLE_W'(SETTLE_SAMPLES - 1)) begin
                        state_d = ST_ACCUM;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                    end
                end
            end
            ST_ACCUM: begin
                if (tick) begin
                    avg_en_d     = 1'b1;
                    sample_cnt_d = sample_cnt_q + SAMPLE_W'(1);
                    if (sample_cnt_q == SAMPLE_W'((1 << POWER) - 1)) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                result_valid_d = 1'b1;
                result_data_d  = avg_Q;
                result_ch_d    = ch_sel_q;
                rr_ptr_d       = ptr_after_cap;
                if (have_ch) begin
                    ch_sel_d = CH_W'(rr_next(MAX_CH'(ch_mask), 3'(ptr_after_cap), NUM_CH));
                    state_d  = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort: the window is already complete once CAPTURE is reached, so
        // CAPTURE itself handles enable low by publishing and going idle.
        if (!enable && (state_q != ST_IDLE) && (state_q != ST_CAPTURE)) begin
            state_d  = ST_IDLE;
            avg_en_d = 1'b0;
        end

        // Strobes decoded from the next state so they are registered yet
        // coincide with the CLEAR / IDLE cycles themselves.
        avg_clr_d = (state_d == ST_CLEAR);
        ready_d   = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            ch_sel_q       <= '0;
            rr_ptr_q       <= '0;
            settle_cnt_q   <= '0;
            sample_cnt_q   <= '0;
            avg_en_q       <= 1'b0;
            avg_clr_q      <= 1'b0;
            result_valid_q <= 1'b0;
            result_data_q  <= '0;
            result_ch_q    <= '0;
            ready_q        <= 1'b1;
        end else begin
            state_q        <= state_d;
            ch_sel_q       <= ch_sel_d;
            rr_ptr_q       <= rr_ptr_d;
            settle_cnt_q   <= settle_cnt_d;
            sample_cnt_q   <= sample_cnt_d;
            avg_en_q       <= avg_en_d;
            avg_clr_q      <= avg_clr_d;
            result_valid_q <= result_valid_d;
            result_data_q  <= result_data_d;
            result_ch_q    <= result_ch_d;
            ready_q        <= ready_d;
        end
    end

    assign ch_sel       = ch_sel_q;
    assign avg_EN       = avg_en_q;
    assign avg_clr      = avg_clr_q;
    assign result_valid = result_valid_q;
    assign result_data  = result_data_q;
    assign result_ch    = result_ch_q;
    assign ready        = ready_q;

`ifdef ADC_SCHED_HOLD_EN
    logic [ADC_CODE_W-1:0] bank_q [NUM_CH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                bank_q[i] <= '0;
            end else if ((state_q == ST_CAPTURE) && (ch_sel_q == CH_W'(i))) begin
                bank_q[i] <= avg_Q;
            end
        end
    end

    // Select loop rather than a direct index so rd_ch values beyond
    // NUM_CH-1 fall through to zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                rd_data = bank_q[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// ---------------------------------------------------------------------------
// tb_adc_channel_scheduler
// Randomized self-checking bench. A reference model predicts, for every
// scheduling session, the channel order (round-robin over the mask), the
// cycle of every avg_clr / avg_EN / result_valid, and the captured codes;
// a negedge monitor logs what the DUT actually did.
// ---------------------------------------------------------------------------
module tb_adc_channel_scheduler;
    import adc_sched_pkg::*;

    localparam int NUM_CH  = 3;
    localparam int POWER   = 2;
    localparam int SD      = 4;
    localparam int SETTLE  = 1;
    localparam int CH_W    = ch_width(NUM_CH);
    localparam int NSAMP   = 1 << POWER;
    // CLEAR-to-next-CLEAR spacing of back-to-back windows
    localparam int WIN_LEN = (SETTLE + NSAMP) * SD + 3;

    logic                  clk;
    logic                  reset;
    logic                  enable;
    logic [NUM_CH-1:0]     ch_mask;
    logic [ADC_CODE_W-1:0] avg_Q;
    logic [CH_W-1:0]       ch_sel;
    logic                  avg_EN;
    logic                  avg_clr;
    logic                  result_valid;
    logic [ADC_CODE_W-1:0] result_data;
    logic [CH_W-1:0]       result_ch;
    logic                  ready;
`ifdef ADC_SCHED_HOLD_EN
    logic [CH_W-1:0]       rd_ch;
    logic [ADC_CODE_W-1:0] rd_data;
`endif

    adc_channel_scheduler #(
        .NUM_CH         (NUM_CH),
        .POWER          (POWER),
        .SAMPLE_DIV     (SD),
        .SETTLE_SAMPLES (SETTLE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .ch_mask      (ch_mask),
        .avg_Q        (avg_Q),
`ifdef ADC_SCHED_HOLD_EN
        .rd_ch        (rd_ch),
        .rd_data      (rd_data),
`endif
        .ch_sel       (ch_sel),
        .avg_EN       (avg_EN),
        .avg_clr      (avg_clr),
        .result_valid (result_valid),
        .result_data  (result_data),
        .result_ch    (result_ch),
        .ready        (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log written only by the monitor.
    int clr_log[$];
    int en_log[$];
    int rv_cyc_log[$];
    int rv_ch_log[$];
    int rv_data_log[$];
    int overlap_cnt = 0;

    always @(negedge clk) begin
        if (avg_clr === 1'b1) clr_log.push_back(cyc);
        if (avg_EN === 1'b1) en_log.push_back(cyc);
        if (result_valid === 1'b1) begin
            rv_cyc_log.push_back(cyc);
            rv_ch_log.push_back(int'(result_ch));
            rv_data_log.push_back(int'(result_data));
        end
        if (avg_clr === 1'b1 && avg_EN === 1'b1) overlap_cnt <= overlap_cnt + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int ptr_m = 0;
    logic [NUM_CH-1:0]     win_mask [8];
    logic [ADC_CODE_W-1:0] win_q    [8];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: first set mask bit at or after p, wrapping over NUM_CH.
    function automatic int pick_ch(input logic [NUM_CH-1:0] m, input int p);
        for (int i = 0; i < NUM_CH; i++) begin
            if (m[(p + i) % NUM_CH]) return (p + i) % NUM_CH;
        end
        return -1;
    endfunction

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ch_sel"}, int'(ch_sel), 0);
        check_eq({tag, "_avg_EN"}, int'(avg_EN), 0);
        check_eq({tag, "_avg_clr"}, int'(avg_clr), 0);
        check_eq({tag, "_result_valid"}, int'(result_valid), 0);
        check_eq({tag, "_result_data"}, int'(result_data), 0);
        check_eq({tag, "_result_ch"}, int'(result_ch), 0);
        check_eq({tag, "_ready"}, int'(ready), 1);
    endtask

    task automatic apply_reset();
        reset  = 1'b1;
        enable = 1'b0;
        step();
        step();
        reset  = 1'b0;
        ptr_m  = 0;
        step();
    endtask

    // Run nwin back-to-back windows using win_mask/win_q; each window's
    // mask is changed mid-way through the previous window, and the mask
    // goes to zero during the last window so the scheduler returns idle.
    task automatic run_session(input int nwin);
        int b_clr, b_en, b_rv, c0, stop;
        int ch_exp [8];
        b_clr = clr_log.size();
        b_en  = en_log.size();
        b_rv  = rv_cyc_log.size();
        c0    = cyc + 1;
        ch_mask = win_mask[0];
        avg_Q   = win_q[0];
        enable  = 1'b1;
        for (int w = 0; w < nwin; w++) begin
            ch_exp[w] = pick_ch(win_mask[w], ptr_m);
            ptr_m     = (ch_exp[w] + 1) % NUM_CH;
        end
        stop = c0 + nwin * WIN_LEN + 4;
        while (cyc < stop) begin
            step();
            for (int w = 0; w < nwin; w++) begin
                if (cyc == c0 + w * WIN_LEN) avg_Q = win_q[w];
                if (cyc == c0 + w * WIN_LEN + WIN_LEN / 2)
                    ch_mask = (w + 1 < nwin) ? win_mask[w + 1] : '0;
            end
        end
        enable = 1'b0;
        check_eq("clr_count", clr_log.size() - b_clr, nwin);
        check_eq("en_count", en_log.size() - b_en, nwin * NSAMP);
        check_eq("rv_count", rv_cyc_log.size() - b_rv, nwin);
        check_eq("ready_after", int'(ready), 1);
        for (int w = 0; w < nwin; w++) begin
            if (b_clr + w < clr_log.size())
                check_eq("clr_cycle", clr_log[b_clr + w] - c0, w * WIN_LEN);
            for (int k = 0; k < NSAMP; k++) begin
                if (b_en + w * NSAMP + k < en_log.size())
                    check_eq("en_cycle", en_log[b_en + w * NSAMP + k] - c0,
                             w * WIN_LEN + 1 + (SETTLE + 1 + k) * SD);
            end
            if (b_rv + w < rv_cyc_log.size()) begin
                $display("window %0d: ch=%0d data=%03h (expect ch=%0d data=%03h)", w,
                         rv_ch_log[b_rv + w], rv_data_log[b_rv + w], ch_exp[w], win_q[w]);
                check_eq("rv_cycle", rv_cyc_log[b_rv + w] - c0, (w + 1) * WIN_LEN);
                check_eq("rv_ch", rv_ch_log[b_rv + w], ch_exp[w]);
                check_eq("rv_data", rv_data_log[b_rv + w], int'(win_q[w]));
            end
        end
    endtask

    // Start one window and drop enable right after its 2nd avg_EN.
    task automatic run_abort(input logic [NUM_CH-1:0] m);
        int b_clr, b_en, b_rv, c0, a, exp_ch;
        b_clr  = clr_log.size();
        b_en   = en_log.size();
        b_rv   = rv_cyc_log.size();
        c0     = cyc + 1;
        exp_ch = pick_ch(m, ptr_m);
        ch_mask = m;
        enable  = 1'b1;
        a = c0 + 1 + (SETTLE + 2) * SD;
        while (cyc < a) step();
        enable = 1'b0;
        step();
        check_eq("abort_ready", int'(ready), 1);
        repeat (WIN_LEN + 4) step();
        $display("abort: ch_sel=%0d en=%0d rv=%0d", ch_sel, en_log.size() - b_en,
                 rv_cyc_log.size() - b_rv);
        check_eq("abort_clr_count", clr_log.size() - b_clr, 1);
        check_eq("abort_en_count", en_log.size() - b_en, 2);
        check_eq("abort_rv_count", rv_cyc_log.size() - b_rv, 0);
        check_eq("abort_ch_sel", int'(ch_sel), exp_ch);
    endtask

    task automatic run_reset_mid(input logic [NUM_CH-1:0] m, input int dly);
        ch_mask = m;
        enable  = 1'b1;
        repeat (dly) step();
        reset  = 1'b1;
        enable = 1'b0;
        step();
        $display("reset after %0d cycles", dly);
        check_reset_vals("midrst");
        reset = 1'b0;
        ptr_m = 0;
        step();
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        ch_mask = '0;
        avg_Q   = '0;
`ifdef ADC_SCHED_HOLD_EN
        rd_ch   = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        check_reset_vals("rst");

        // enable with empty mask must stay idle
        begin
            int b_clr;
            b_clr   = clr_log.size();
            enable  = 1'b1;
            ch_mask = '0;
            repeat (6) step();
            check_eq("empty_mask_ready", int'(ready), 1);
            check_eq("empty_mask_clr", clr_log.size() - b_clr, 0);
            enable = 1'b0;
            step();
        end

        // single channel window
        win_mask[0] = 3'b001;
        win_q[0]    = 12'h0A5;
        run_session(1);

        // alternating channels 0,2,0,2 from a fresh pointer
        apply_reset();
        for (int w = 0; w < 4; w++) begin
            win_mask[w] = 3'b101;
            win_q[w]    = ADC_CODE_W'($urandom);
        end
        run_session(4);

        // abort mid-accumulation
        run_abort(3'b011);

        // mask change mid-window takes effect at next selection
        win_mask[0] = 3'b001;
        win_mask[1] = 3'b010;
        win_q[0]    = 12'h3C3;
        win_q[1]    = 12'h7E1;
        run_session(2);

        // randomized mix of sessions, aborts and mid-window resets
        for (int it = 0; it < 16; it++) begin
            int kind;
            kind = int'($urandom_range(0, 5));
            if (kind == 0) begin
                run_abort(NUM_CH'($urandom_range(1, 7)));
            end else if (kind == 1) begin
                run_reset_mid(NUM_CH'($urandom_range(1, 7)), int'($urandom_range(2, 60)));
            end else begin
                int nw;
                nw = int'($urandom_range(1, 4));
                for (int w = 0; w < nw; w++) begin
                    win_mask[w] = NUM_CH'($urandom_range(1, 7));
                    win_q[w]    = ADC_CODE_W'($urandom);
                end
                run_session(nw);
            end
        end

`ifdef ADC_SCHED_HOLD_EN
        apply_reset();
        win_mask[0] = 3'b001;
        win_mask[1] = 3'b100;
        win_q[0]    = 12'h111;
        win_q[1]    = 12'h222;
        run_session(2);
        rd_ch = 2'd2;
        #1;
        check_eq("rd_ch2", int'(rd_data), 12'h222);
        rd_ch = 2'd1;
        #1;
        check_eq("rd_ch1", int'(rd_data), 0);
        rd_ch = 2'd3;
        #1;
        check_eq("rd_ch3", int'(rd_data), 0);
        rd_ch = 2'd0;
        #1;
        check_eq("rd_ch0", int'(rd_data), 12'h111);
`endif

        check_eq("clr_en_overlap", overlap_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
